// File: rtl/button_bounce_gen_if.sv
// Request/response bundle between a button-press requester and the bounce generator.
// The requester drives start/presses; the generator returns the emulated key and status.
interface button_bounce_gen_if #(
   parameter int CNT_W = 10
);
   logic             start;
   logic [CNT_W-1:0] presses;
   logic             button;
   logic             busy;
   logic             done;

   modport master (
      output start,
      output presses,
      input  button,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  presses,
      output button,
      output busy,
      output done
   );
endinterface

// File: rtl/button_bounce_gen.sv
// Emulated active-low push button: emits N press/release events, each edge followed
// by a burst of bounce toggles and a stable hold, then pulses done.
//
//   state        | meaning
//   -------------+-------------------------------------------------------------
//   IDLE         | button released (1); waits for start
//   PRESS_BOUNCE | main falling edge, then 2*BOUNCES bounce toggles
//   PRESS_HOLD   | button held low for HOLD_CYCLES
//   REL_BOUNCE   | bounce toggles after the main rising edge
//   REL_HOLD     | button held high; next press or finish with done
module button_bounce_gen #(
   parameter int BOUNCE_CYCLES = 3000,
   parameter int BOUNCES       = 2,
   parameter int HOLD_CYCLES   = 988000,
   parameter int CNT_W         = 10
) (
   input  logic                clock,
   input  logic                reset,
   button_bounce_gen_if.slave  bus
);

   localparam int MAX_CYC = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
   localparam int TMR_W   = $clog2(MAX_CYC + 1);
   localparam int TOGGLES = 2 * BOUNCES;
   localparam int BCNT_W  = (TOGGLES > 0) ? $clog2(TOGGLES + 1) : 1;

   localparam logic [TMR_W-1:0]  BOUNCE_LOAD = TMR_W'(BOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0]  HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST   = BCNT_W'(TOGGLES);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_BOUNCE,
      PRESS_HOLD,
      REL_BOUNCE,
      REL_HOLD
   } state_t;

   state_t             state, state_n;
   logic [TMR_W-1:0]   timer, timer_n;
   logic [BCNT_W-1:0]  bcnt, bcnt_n;
   logic [CNT_W-1:0]   remaining, remaining_n;
   logic               button_q, button_n;
   logic               busy_q, busy_n;
   logic               done_q, done_n;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         timer     <= '0;
         bcnt      <= '0;
         remaining <= '0;
         button_q  <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         bcnt      <= bcnt_n;
         remaining <= remaining_n;
         button_q  <= button_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
      end
   end

   always_comb begin
      state_n     = state;
      timer_n     = timer;
      bcnt_n      = bcnt;
      remaining_n = remaining;
      button_n    = button_q;
      busy_n      = busy_q;
      done_n      = 1'b0;

      case (state)
         IDLE: begin
            button_n = 1'b1;
            busy_n   = 1'b0;
            timer_n  = '0;
            bcnt_n   = '0;
            if (bus.start) begin
               if (bus.presses != '0) begin
                  remaining_n = bus.presses;
                  state_n     = PRESS_BOUNCE;
               end else begin
                  done_n = 1'b1;
               end
            end
         end

         // bcnt==0 only happens on the first press after start; later main edges
         // are issued by the hold states so each phase starts exactly on time.
         PRESS_BOUNCE, REL_BOUNCE: begin
            busy_n = 1'b1;
            if (timer == '0) begin
               if (bcnt == '0) button_n = (state == REL_BOUNCE);
               else            button_n = ~button_q;
               if (bcnt == BCNT_LAST) begin
                  state_n = (state == PRESS_BOUNCE) ? PRESS_HOLD : REL_HOLD;
                  timer_n = HOLD_LOAD;
                  bcnt_n  = '0;
               end else begin
                  bcnt_n  = bcnt + 1'b1;
                  timer_n = BOUNCE_LOAD;
               end
            end else begin
               timer_n = timer - 1'b1;
            end
         end

         PRESS_HOLD: begin
            if (timer == '0) begin
               button_n = 1'b1;
               if (TOGGLES == 0) begin
                  state_n = REL_HOLD;
                  timer_n = HOLD_LOAD;
                  bcnt_n  = '0;
               end else begin
                  state_n = REL_BOUNCE;
                  timer_n = BOUNCE_LOAD;
                  bcnt_n  = BCNT_W'(1);
               end
            end else begin
               timer_n = timer - 1'b1;
            end
         end

         REL_HOLD: begin
            if (timer == '0) begin
               remaining_n = remaining - 1'b1;
               if (remaining == CNT_W'(1)) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  button_n = 1'b0;
                  if (TOGGLES == 0) begin
                     state_n = PRESS_HOLD;
                     timer_n = HOLD_LOAD;
                     bcnt_n  = '0;
                  end else begin
                     state_n = PRESS_BOUNCE;
                     timer_n = BOUNCE_LOAD;
                     bcnt_n  = BCNT_W'(1);
                  end
               end
            end else begin
               timer_n = timer - 1'b1;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.button = button_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: expected button/busy/done events are queued from a
// timing model when a request is issued and matched against the observed event stream.
module tb_button_bounce_gen;

   localparam int BC = 3;
   localparam int NB = 2;
   localparam int HC = 20;
   localparam int CW = 10;
   localparam int P  = 2 * NB * BC + HC;
   localparam int PB = HC;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  kind;
      logic        val;
   } ev_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   ev_t exp_q[$];
   ev_t obs_a[$];
   ev_t obs_b[$];

   logic pa_btn = 1'b1, pa_busy = 1'b0;
   logic pb_btn = 1'b1, pb_busy = 1'b0;

   always #5 clock = ~clock;

   button_bounce_gen_if #(.CNT_W(CW)) bus_a ();
   button_bounce_gen_if #(.CNT_W(CW)) bus_b ();

   button_bounce_gen #(
      .BOUNCE_CYCLES(BC), .BOUNCES(NB), .HOLD_CYCLES(HC), .CNT_W(CW)
   ) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a.slave)
   );

   button_bounce_gen #(
      .BOUNCE_CYCLES(BC), .BOUNCES(0), .HOLD_CYCLES(HC), .CNT_W(CW)
   ) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b.slave)
   );

   function automatic ev_t mk(input int c, input int k, input logic v);
      ev_t e;
      e.cyc  = 32'(c);
      e.kind = 2'(k);
      e.val  = v;
      return e;
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   // kind 0 = button change, 1 = busy change, 2 = done pulse
   always @(negedge clock) begin
      if (bus_a.button !== pa_btn) begin obs_a.push_back(mk(cyc, 0, bus_a.button)); pa_btn = bus_a.button; end
      if (bus_a.busy !== pa_busy)  begin obs_a.push_back(mk(cyc, 1, bus_a.busy));   pa_busy = bus_a.busy;  end
      if (bus_a.done === 1'b1)     obs_a.push_back(mk(cyc, 2, 1'b1));
      if (bus_b.button !== pb_btn) begin obs_b.push_back(mk(cyc, 0, bus_b.button)); pb_btn = bus_b.button; end
      if (bus_b.busy !== pb_busy)  begin obs_b.push_back(mk(cyc, 1, bus_b.busy));   pb_busy = bus_b.busy;  end
      if (bus_b.done === 1'b1)     obs_b.push_back(mk(cyc, 2, 1'b1));
   end

   task automatic gen_seq(input int t0, input int n, input int nb, input int bc, input int h);
      int p;
      int base;
      p = 2 * nb * bc + h;
      for (int k = 0; k < n; k++) begin
         base = t0 + 2 * k * p;
         exp_q.push_back(mk(base, 0, 1'b0));
         if (k == 0) exp_q.push_back(mk(base, 1, 1'b1));
         for (int j = 1; j <= 2 * nb; j++) exp_q.push_back(mk(base + j * bc, 0, logic'(j % 2)));
         exp_q.push_back(mk(base + p, 0, 1'b1));
         for (int j = 1; j <= 2 * nb; j++) exp_q.push_back(mk(base + p + j * bc, 0, logic'((j + 1) % 2)));
      end
      exp_q.push_back(mk(t0 + 2 * n * p, 1, 1'b0));
      exp_q.push_back(mk(t0 + 2 * n * p, 2, 1'b1));
   endtask

   task automatic do_start(input bit use_b, input int p, output int t0);
      @(negedge clock);
      if (use_b) begin bus_b.start = 1'b1; bus_b.presses = CW'(p); end
      else       begin bus_a.start = 1'b1; bus_a.presses = CW'(p); end
      t0 = cyc + 2;
      @(negedge clock);
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
   endtask

   task automatic test_reset();
      int dones;
      #1 reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         bus_a.start   = (i % 2 == 0);
         bus_a.presses = CW'(5);
         vectors++;
         if (bus_a.button !== 1'b1 || bus_a.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got button=%0b busy=%0b, need button=1 busy=0", bus_a.button, bus_a.busy);
         end
      end
      @(negedge clock);
      bus_a.start = 1'b0;
      reset = 1'b1;
      repeat (5) @(negedge clock);
      dones = 0;
      foreach (obs_a[i]) if (obs_a[i].kind == 2'd2) dones++;
      vectors++;
      if (dones != 0) begin
         miscompares++;
         $display("FAIL reset_done: got %0d done pulses, need 0", dones);
      end
      vectors++;
      if (bus_a.busy !== 1'b0 || bus_a.button !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release: got button=%0b busy=%0b, need button=1 busy=0", bus_a.button, bus_a.busy);
      end
      obs_a.delete();
      obs_b.delete();
   endtask

   task automatic test_single_press();
      int t0;
      ev_t e, o;
      obs_a.delete(); exp_q.delete();
      do_start(0, 1, t0);
      gen_seq(t0, 1, NB, BC, HC);
      while (cyc < t0 + 2 * P + 4) @(negedge clock);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_a.size() == 0) begin
            miscompares++;
            $display("FAIL single_press: got no event, need cyc=t0+%0d kind=%0d val=%0b", int'(e.cyc) - t0, e.kind, e.val);
         end else begin
            o = obs_a.pop_front();
            if (o !== e) begin
               miscompares++;
               $display("FAIL single_press: got cyc=t0+%0d kind=%0d val=%0b, need cyc=t0+%0d kind=%0d val=%0b",
                        int'(o.cyc) - t0, o.kind, o.val, int'(e.cyc) - t0, e.kind, e.val);
            end
         end
      end
      vectors++;
      if (obs_a.size() != 0) begin
         miscompares++;
         $display("FAIL single_press_extra: got %0d extra events, need 0", obs_a.size());
      end
   endtask

   task automatic test_zero_and_ignored();
      int t0;
      int e0;
      ev_t e, o;
      obs_a.delete(); exp_q.delete();
      @(negedge clock);
      bus_a.start = 1'b1; bus_a.presses = '0;
      e0 = cyc + 1;
      @(negedge clock);
      bus_a.start = 1'b0;
      exp_q.push_back(mk(e0, 2, 1'b1));
      repeat (5) @(negedge clock);
      do_start(0, 3, t0);
      gen_seq(t0, 3, NB, BC, HC);
      while (cyc < t0 + 50) @(negedge clock);
      bus_a.start = 1'b1; bus_a.presses = CW'(7);
      @(negedge clock);
      bus_a.start = 1'b0;
      while (cyc < t0 + 6 * P + 5) @(negedge clock);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_a.size() == 0) begin
            miscompares++;
            $display("FAIL zero_ignored: got no event, need cyc=%0d kind=%0d val=%0b", e.cyc, e.kind, e.val);
         end else begin
            o = obs_a.pop_front();
            if (o !== e) begin
               miscompares++;
               $display("FAIL zero_ignored: got cyc=%0d kind=%0d val=%0b, need cyc=%0d kind=%0d val=%0b",
                        o.cyc, o.kind, o.val, e.cyc, e.kind, e.val);
            end
         end
      end
      vectors++;
      if (obs_a.size() != 0) begin
         miscompares++;
         $display("FAIL zero_ignored_extra: got %0d extra events, need 0", obs_a.size());
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      bit got;
      ev_t e, o;
      obs_a.delete(); exp_q.delete();
      do_start(0, 1, t0);
      gen_seq(t0, 1, NB, BC, HC);
      gen_seq(t0 + 2 * P + 2, 1, NB, BC, HC);
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clock);
         if (bus_a.done === 1'b1) got = 1;
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL back_to_back_timeout: got no done in 200 cycles, need done at t0+%0d", 2 * P);
      end else begin
         bus_a.start = 1'b1; bus_a.presses = CW'(1);
         @(negedge clock);
         bus_a.start = 1'b0;
         while (cyc < t0 + 4 * P + 6) @(negedge clock);
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); vectors++;
            if (obs_a.size() == 0) begin
               miscompares++;
               $display("FAIL back_to_back: got no event, need cyc=t0+%0d kind=%0d val=%0b", int'(e.cyc) - t0, e.kind, e.val);
            end else begin
               o = obs_a.pop_front();
               if (o !== e) begin
                  miscompares++;
                  $display("FAIL back_to_back: got cyc=t0+%0d kind=%0d val=%0b, need cyc=t0+%0d kind=%0d val=%0b",
                           int'(o.cyc) - t0, o.kind, o.val, int'(e.cyc) - t0, e.kind, e.val);
               end
            end
         end
         vectors++;
         if (obs_a.size() != 0) begin
            miscompares++;
            $display("FAIL back_to_back_extra: got %0d extra events, need 0", obs_a.size());
         end
      end
   endtask

   task automatic test_mid_reset();
      int t0;
      ev_t e, o;
      obs_a.delete(); exp_q.delete();
      do_start(0, 1, t0);
      while (cyc < t0 + 40) @(negedge clock);
      vectors++;
      if (bus_a.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset_pre: got busy=%0b, need 1", bus_a.busy);
      end
      #1 reset = 1'b0;
      #1;
      vectors++;
      if (bus_a.button !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_async: got button=%0b busy=%0b done=%0b, need 1 0 0", bus_a.button, bus_a.busy, bus_a.done);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      obs_a.delete(); obs_b.delete();
      do_start(0, 1, t0);
      gen_seq(t0, 1, NB, BC, HC);
      while (cyc < t0 + 2 * P + 4) @(negedge clock);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_a.size() == 0) begin
            miscompares++;
            $display("FAIL mid_reset_rerun: got no event, need cyc=t0+%0d kind=%0d val=%0b", int'(e.cyc) - t0, e.kind, e.val);
         end else begin
            o = obs_a.pop_front();
            if (o !== e) begin
               miscompares++;
               $display("FAIL mid_reset_rerun: got cyc=t0+%0d kind=%0d val=%0b, need cyc=t0+%0d kind=%0d val=%0b",
                        int'(o.cyc) - t0, o.kind, o.val, int'(e.cyc) - t0, e.kind, e.val);
            end
         end
      end
      vectors++;
      if (obs_a.size() != 0) begin
         miscompares++;
         $display("FAIL mid_reset_extra: got %0d extra events, need 0", obs_a.size());
      end
   endtask

   task automatic test_clean_edges();
      int t0;
      ev_t e, o;
      obs_b.delete(); exp_q.delete();
      do_start(1, 2, t0);
      gen_seq(t0, 2, 0, BC, HC);
      while (cyc < t0 + 4 * PB + 5) @(negedge clock);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_b.size() == 0) begin
            miscompares++;
            $display("FAIL clean_edges: got no event, need cyc=t0+%0d kind=%0d val=%0b", int'(e.cyc) - t0, e.kind, e.val);
         end else begin
            o = obs_b.pop_front();
            if (o !== e) begin
               miscompares++;
               $display("FAIL clean_edges: got cyc=t0+%0d kind=%0d val=%0b, need cyc=t0+%0d kind=%0d val=%0b",
                        int'(o.cyc) - t0, o.kind, o.val, int'(e.cyc) - t0, e.kind, e.val);
            end
         end
      end
      vectors++;
      if (obs_b.size() != 0) begin
         miscompares++;
         $display("FAIL clean_edges_extra: got %0d extra events, need 0", obs_b.size());
      end
   endtask

   initial begin
      bus_a.start = 1'b0; bus_a.presses = '0;
      bus_b.start = 1'b0; bus_b.presses = '0;
      test_reset();
      test_single_press();
      test_zero_and_ignored();
      test_back_to_back();
      test_mid_reset();
      test_clean_edges();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by time limit, need bench to finish");
      $fatal(1);
   end

endmodule

// File: doc/button_bounce_gen.md
# button_bounce_gen

Synthesizable button-press emulator that produces a mechanically realistic, bouncing, active-low button waveform. It is the transmit side of the button debouncer and press counter: it drives that block's `button` input in on-board self-test and in simulation without a hand-written stimulus process. On a start request it emits a programmed number of press/release events. Each event has a configurable bounce burst on every edge followed by a stable hold, and the block signals completion.

## Interface
Parameters:
- `BOUNCE_CYCLES`, default 3000: clock cycles between successive bounce toggles; must be ≥ 1.
- `BOUNCES`, default 2: number of glitch pairs (two extra toggles each) after every main edge; ≥ 0.
- `HOLD_CYCLES`, default 988000: stable cycles after the last bounce toggle before the next main edge; must be ≥ 1.
- `CNT_W`, default 10: width of the press-count request.

Ports:
- `clock`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `presses`  in  CNT_W  number of press/release events; sampled with `start`.
- `button`  out  1  emulated key, active low (idle/released = 1).
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.

## Operation
- Reset (`reset`=0, asynchronous) forces `button`=1, `busy`=0, `done`=0, state IDLE, and clears all counters. This applies immediately, including mid-sequence.
- States: IDLE → PRESS_BOUNCE → PRESS_HOLD → REL_BOUNCE → REL_HOLD. REL_HOLD returns to PRESS_BOUNCE if presses remain, otherwise goes to IDLE with `done`.
- IDLE with `start`=1 and `presses`≠0: latch `presses` into the remaining counter, set `busy`=1, and enter PRESS_BOUNCE.
- IDLE with `start`=1 and `presses`=0: pulse `done` on the next cycle; `busy` and `button` do not change.
- `start` outside IDLE is ignored. A new `presses` value has no effect until the block is back in IDLE.
- PRESS_BOUNCE: `button` drives the main edge to 0, then makes 2·BOUNCES toggles spaced BOUNCE_CYCLES apart. Because the toggle count is even, the level ends at 0. The state then moves to PRESS_HOLD.
- PRESS_HOLD: `button` holds 0 for HOLD_CYCLES.
- REL_BOUNCE and REL_HOLD mirror the press phases with the main edge to 1.
- The remaining-press counter decrements at the end of REL_HOLD.
- With BOUNCES=0 each phase is a single clean edge.
- Timer width is ceil(log2(max(BOUNCE_CYCLES, HOLD_CYCLES)+1)). The bounce counter counts 0..2·BOUNCES. All counters are unsigned and never wrap.

## Timing
- Let t0 be the first clock edge after `start` is sampled. `button` falls at t0 (one-cycle latency), and `busy` rises at t0.
- Half-period P = 2·BOUNCES·BOUNCE_CYCLES + HOLD_CYCLES.
- Press k (k = 0..N−1) has its main falling edge at t0 + 2kP.
  - Its bounce toggles occur at that edge + j·BOUNCE_CYCLES, for j = 1..2·BOUNCES.
  - Its main rising edge occurs at t0 + (2k+1)P.
- Release bounces follow the same spacing as press bounces.
- At t0 + 2NP:
  - `busy` falls and `done` is high for exactly that one cycle.
  - `button` is 1 and stays 1.
  - The block is back in IDLE and will accept `start` in the same cycle that `done` is high.
- `button`, `busy` and `done` are registered outputs with no combinational path from inputs.

## Test plan
Use BOUNCE_CYCLES=3, BOUNCES=2, HOLD_CYCLES=20 (P=32) unless noted.
- Reset hold: hold `reset`=0 for 10 cycles while pulsing `start` with `presses`=5 → `button`=1, `busy`=0, and `done` never pulses.
- Single press: `start` with `presses`=1 → `button` edges at t0, t0+3, t0+6, t0+9, t0+12 (low after), rise at t0+32 with four bounce toggles, then `done`=1 at t0+64 only, with `busy` high for exactly 64 cycles.
- Multi-press into the debouncer/counter: `presses`=3 → 3 falling main edges at t0, t0+64, t0+128. Also, with BOUNCE_CYCLES=3000 and HOLD_CYCLES=988000, the attached counter LEDs read 3 after `done`.
- Zero and ignored requests: `presses`=0 → `done` one cycle after `start`, no `button` edge. A `start` with `presses`=7 issued mid-sequence does not change the 3-press sequence, which still ends at t0+192.
- Mid-operation reset: assert `reset`=0 at t0+40 → `button`=1 and `busy`=0 asynchronously before the next clock. After release, a new `start` with `presses`=1 runs a full 64-cycle sequence.
- Clean edges: with BOUNCES=0 and `presses`=2 → exactly 4 `button` transitions, 20 cycles apart, with `done` at t0+80.
